// File: rtl/jt49_bus_master_if.sv
// Command/response and PSG pin bundle for jt49_bus_master.
// The master modport is the sequencer's view; slave is the host plus chip side.
interface jt49_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rd;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       bdir;
    logic       bc1;
    logic [7:0] bus_dout;
    logic       bus_oe;
    logic [7:0] bus_din;

    modport master (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_data, bus_din,
        output cmd_ready, rsp_valid, rsp_data, busy, bdir, bc1, bus_dout, bus_oe
    );

    modport slave (
        output cmd_valid, cmd_rd, cmd_addr, cmd_data, bus_din,
        input  cmd_ready, rsp_valid, rsp_data, busy, bdir, bc1, bus_dout, bus_oe
    );
endinterface

// File: rtl/jt49_bus_master.sv
// BDIR/BC1 bus initiator for AY-3-8910/YM2149-style chips: a small command FIFO
// feeding an address-latch + write/read sequencer with registered pin outputs.
module jt49_bus_master #(
    parameter int         PHASE_CYC = 4,
    parameter int         GAP_CYC   = 1,
    parameter int         AW        = 2,
    parameter logic [3:0] HIGH_ADDR = 4'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    jt49_bus_master_if.master  bus
);
    localparam int DEPTH = 1 << AW;
    localparam int MAXC  = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, ADDR, GAP1, XFER, GAP2} state_t;

    logic [12:0]   fifo_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          empty, full, push, pop;
    logic [12:0]   head;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [12:0]   cur_q, cur_d;

    logic          bdir_q, bdir_d, bc1_q, bc1_d, oe_q, oe_d;
    logic [7:0]    dout_q, dout_d;
    logic          strobe_q, strobe_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.cmd_valid && !full;
    assign head  = fifo_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Entry layout is {rd, addr[3:0], data[7:0]}; read data field is zeroed.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q[AW-1:0]] <= {bus.cmd_rd, bus.cmd_addr,
                                         bus.cmd_rd ? 8'h00 : bus.cmd_data};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CW'(1);
        cur_d   = cur_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (!empty) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    state_d = ADDR;
                    cnt_d   = CW'(PHASE_CYC);
                end
            end
            ADDR: if (cnt_q == CW'(1)) begin
                state_d = GAP1;
                cnt_d   = CW'(GAP_CYC);
            end
            GAP1: if (cnt_q == CW'(1)) begin
                state_d = XFER;
                cnt_d   = CW'(PHASE_CYC);
            end
            XFER: if (cnt_q == CW'(1)) begin
                state_d = GAP2;
                cnt_d   = CW'(GAP_CYC);
            end
            GAP2: if (cnt_q == CW'(1)) begin
                if (!empty) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    state_d = ADDR;
                    cnt_d   = CW'(PHASE_CYC);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pins follow the state register by one cycle, so the read strobe lines up
    // with the last visible 01 cycle and the response with the first GAP2 cycle.
    always_comb begin
        bdir_d   = 1'b0;
        bc1_d    = 1'b0;
        oe_d     = 1'b0;
        dout_d   = dout_q;
        strobe_d = 1'b0;
        unique case (state_q)
            ADDR: begin
                bdir_d = 1'b1;
                bc1_d  = 1'b1;
                oe_d   = 1'b1;
                dout_d = {HIGH_ADDR, cur_q[11:8]};
            end
            XFER: begin
                if (cur_q[12]) begin
                    bc1_d    = 1'b1;
                    strobe_d = (cnt_q == CW'(1));
                end else begin
                    bdir_d = 1'b1;
                    oe_d   = 1'b1;
                    dout_d = cur_q[7:0];
                end
            end
            default: ;
        endcase
        rsp_valid_d = strobe_q;
        rsp_data_d  = strobe_q ? bus.bus_din : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            bdir_q      <= 1'b0;
            bc1_q       <= 1'b0;
            oe_q        <= 1'b0;
            dout_q      <= '0;
            strobe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            bdir_q      <= bdir_d;
            bc1_q       <= bc1_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            strobe_q    <= strobe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.busy      = !empty || (state_q != IDLE);
    assign bus.bdir      = bdir_q;
    assign bus.bc1       = bc1_q;
    assign bus.bus_oe    = oe_q;
    assign bus.bus_dout  = dout_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_jt49_bus_master.sv
// Directed bench for jt49_bus_master with a behavioural BDIR/BC1 register-file
// responder per instance (chip select nibble 0).
module tb_jt49_bus_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    jt49_bus_master_if bif();
    jt49_bus_master_if hif();

    jt49_bus_master #(.PHASE_CYC(4), .GAP_CYC(1), .AW(2), .HIGH_ADDR(4'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bif));

    jt49_bus_master #(.PHASE_CYC(4), .GAP_CYC(1), .AW(2), .HIGH_ADDR(4'h1)) u_hi (
        .clk(clk), .rst_n(rst_n), .bus(hif));

    // Responder: latch on 11 if the select nibble is 0, write on 10, drive on 01.
    logic [3:0]  r_addr, r2_addr;
    logic        r_ok, r2_ok;
    logic [7:0]  regs [16];
    logic [7:0]  regs2 [16];
    logic [11:0] wlog [$];
    logic [11:0] wlog2 [$];

    always @(posedge clk) begin
        if (bif.bdir && bif.bc1) begin
            r_addr = bif.bus_dout[3:0];
            r_ok   = (bif.bus_dout[7:4] == 4'h0);
        end else if (bif.bdir && !bif.bc1 && r_ok) begin
            regs[r_addr] = bif.bus_dout;
            wlog.push_back({r_addr, bif.bus_dout});
        end
        if (hif.bdir && hif.bc1) begin
            r2_addr = hif.bus_dout[3:0];
            r2_ok   = (hif.bus_dout[7:4] == 4'h0);
        end else if (hif.bdir && !hif.bc1 && r2_ok) begin
            regs2[r2_addr] = hif.bus_dout;
            wlog2.push_back({r2_addr, hif.bus_dout});
        end
    end

    assign bif.bus_din = (!bif.bdir && bif.bc1 && r_ok)  ? regs[r_addr]   : 8'hFF;
    assign hif.bus_din = (!hif.bdir && hif.bc1 && r2_ok) ? regs2[r2_addr] : 8'hFF;

    // Pin-activity monitor for the back-to-back scenario.
    logic mon_en = 1'b0;
    int   mon_cyc, first11, last10, n11, n10;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bif.bdir && bif.bc1) begin
                if (first11 < 0) first11 = mon_cyc;
                n11++;
            end
            if (bif.bdir && !bif.bc1) begin
                last10 = mon_cyc;
                n10++;
            end
            mon_cyc++;
        end
    end

    task automatic send(input logic rd, input logic [3:0] a, input logic [7:0] d);
        int w = 0;
        while (!bif.cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 100) begin
            errors++;
            $display("[TB] FAIL send_ready_timeout: cmd_ready=%0b after %0d cycles, required 1", bif.cmd_ready, w);
        end
        bif.cmd_valid = 1'b1;
        bif.cmd_rd    = rd;
        bif.cmd_addr  = a;
        bif.cmd_data  = d;
        @(posedge clk);
        @(negedge clk);
        bif.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bif.bdir, bif.bc1} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_pins: got %b, required 00", {bif.bdir, bif.bc1});
        end
        checks++;
        if (bif.bus_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_oe: got %b, required 0", bif.bus_oe);
        end
        checks++;
        if (bif.rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rsp_valid: got %b, required 0", bif.rsp_valid);
        end
        checks++;
        if (bif.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b, required 0", bif.busy);
        end
        checks++;
        if (bif.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_cmd_ready: got %b, required 1", bif.cmd_ready);
        end
        checks++;
        if (bif.bus_dout !== 8'h00 || bif.rsp_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data: dout=%h rsp_data=%h, required 00 00", bif.bus_dout, bif.rsp_data);
        end
        checks++;
        if (hif.busy !== 1'b0 || hif.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_hi: busy=%b ready=%b, required 0 1", hif.busy, hif.cmd_ready);
        end
    endtask

    // Cycle k counts from the accept edge: 11 on k=2..5, 10 on k=7..10, else 00.
    task automatic test_write();
        logic [1:0] exp_pins;
        logic       exp_oe;
        wlog.delete();
        send(1'b0, 4'd7, 8'h38);
        for (int k = 0; k <= 12; k++) begin
            exp_pins = (k >= 2 && k <= 5) ? 2'b11 : (k >= 7 && k <= 10) ? 2'b10 : 2'b00;
            exp_oe   = (exp_pins != 2'b00);
            checks++;
            if ({bif.bdir, bif.bc1, bif.bus_oe} !== {exp_pins, exp_oe}) begin
                errors++;
                $display("[TB] FAIL write_pins k=%0d: got %b, required %b", k, {bif.bdir, bif.bc1, bif.bus_oe}, {exp_pins, exp_oe});
            end
            if (exp_pins == 2'b11 || exp_pins == 2'b10) begin
                checks++;
                if (bif.bus_dout !== ((exp_pins == 2'b11) ? 8'h07 : 8'h38)) begin
                    errors++;
                    $display("[TB] FAIL write_dout k=%0d: got %h, required %h", k, bif.bus_dout, (exp_pins == 2'b11) ? 8'h07 : 8'h38);
                end
            end
            if (k == 10 || k == 11) begin
                checks++;
                if (bif.busy !== (k == 10)) begin
                    errors++;
                    $display("[TB] FAIL write_busy k=%0d: got %b, required %b", k, bif.busy, k == 10);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (regs[7] !== 8'h38) begin
            errors++;
            $display("[TB] FAIL write_reg7: got %h, required 38", regs[7]);
        end
    endtask

    task automatic test_read();
        int pulses = 0, n01 = 0, oe_bad = 0;
        logic [7:0] pdata = 8'h00;
        send(1'b0, 4'd0, 8'h5A);
        send(1'b1, 4'd0, 8'hEE);
        for (int k = 0; k < 40; k++) begin
            if (bif.rsp_valid) begin
                pulses++;
                pdata = bif.rsp_data;
            end
            if (!bif.bdir && bif.bc1) begin
                n01++;
                if (bif.bus_oe) oe_bad++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL read_pulses: got %0d, required 1", pulses);
        end
        checks++;
        if (pdata !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL read_data: got %h, required 5a", pdata);
        end
        checks++;
        if (n01 !== 4 || oe_bad !== 0) begin
            errors++;
            $display("[TB] FAIL read_phase: 01 cycles=%0d oe_high=%0d, required 4 0", n01, oe_bad);
        end
        checks++;
        if (bif.rsp_data !== 8'h5A || bif.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_hold: rsp_data=%h busy=%b, required 5a 0", bif.rsp_data, bif.busy);
        end
    endtask

    // One command is popped into the sequencer right away, so 5 are taken before a stall.
    task automatic test_back_to_back();
        int acc = 0, first_stall = -1, w = 0;
        wlog.delete();
        mon_cyc = 0; first11 = -1; last10 = -1; n11 = 0; n10 = 0;
        mon_en = 1'b1;
        bif.cmd_valid = 1'b1;
        bif.cmd_rd    = 1'b0;
        while (acc < 6 && w < 300) begin
            bif.cmd_addr = 4'(acc + 1);
            bif.cmd_data = 8'(8'h11 * (acc + 1));
            if (bif.cmd_ready) acc++;
            else if (first_stall < 0) first_stall = acc;
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        bif.cmd_valid = 1'b0;
        checks++;
        if (first_stall !== 5 || acc !== 6) begin
            errors++;
            $display("[TB] FAIL b2b_ready: stall_after=%0d accepted=%0d, required 5 6", first_stall, acc);
        end
        w = 0;
        while (bif.busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 200) begin
            errors++;
            $display("[TB] FAIL b2b_idle_timeout: busy=%b, required 0", bif.busy);
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (n11 !== 24 || n10 !== 24 || (last10 - first11) !== 58) begin
            errors++;
            $display("[TB] FAIL b2b_span: n11=%0d n10=%0d span=%0d, required 24 24 58", n11, n10, last10 - first11);
        end
        checks++;
        if (wlog.size() !== 24) begin
            errors++;
            $display("[TB] FAIL b2b_wcount: got %0d, required 24", wlog.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (wlog[j*4] !== {4'(j + 1), 8'(8'h11 * (j + 1))}) begin
                    errors++;
                    $display("[TB] FAIL b2b_order j=%0d: got %h, required %h", j, wlog[j*4], {4'(j + 1), 8'(8'h11 * (j + 1))});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int w = 0, active = 0, busy_seen = 0, lost = 0;
        wlog.delete();
        send(1'b0, 4'd3, 8'h77);
        send(1'b0, 4'd4, 8'h66);
        while (!(bif.bdir && !bif.bc1) && w < 40) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 40) begin
            errors++;
            $display("[TB] FAIL mid_xfer_timeout: pins=%b, required 10", {bif.bdir, bif.bc1});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bif.bdir, bif.bc1, bif.bus_oe, bif.busy, bif.cmd_ready, bif.rsp_valid} !== 6'b000010) begin
            errors++;
            $display("[TB] FAIL mid_reset: pins/oe/busy/ready/rsp=%b, required 000010",
                     {bif.bdir, bif.bc1, bif.bus_oe, bif.busy, bif.cmd_ready, bif.rsp_valid});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bif.bdir || bif.bc1) active++;
            if (bif.busy) busy_seen++;
        end
        foreach (wlog[i]) if (wlog[i][11:8] == 4'd4) lost++;
        checks++;
        if (active !== 0 || busy_seen !== 0 || lost !== 0) begin
            errors++;
            $display("[TB] FAIL mid_lost: active=%0d busy=%0d reg4_writes=%0d, required 0 0 0", active, busy_seen, lost);
        end
    endtask

    task automatic test_high_addr();
        int n11h = 0, bad = 0;
        hif.cmd_valid = 1'b1;
        hif.cmd_rd    = 1'b0;
        hif.cmd_addr  = 4'hA;
        hif.cmd_data  = 8'h55;
        @(posedge clk);
        @(negedge clk);
        hif.cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (hif.bdir && hif.bc1) begin
                n11h++;
                if (hif.bus_dout !== 8'h1A) bad++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (n11h !== 4 || bad !== 0) begin
            errors++;
            $display("[TB] FAIL hi_addr: addr cycles=%0d wrong dout=%0d last=%h, required 4 0 1a", n11h, bad, hif.bus_dout);
        end
        checks++;
        if (wlog2.size() !== 0 || regs2[10] !== 8'h00 || hif.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hi_unchanged: writes=%0d reg10=%h busy=%b, required 0 00 0", wlog2.size(), regs2[10], hif.busy);
        end
    endtask

    initial begin
        r_ok = 1'b0;
        r2_ok = 1'b0;
        r_addr = 4'h0;
        r2_addr = 4'h0;
        for (int i = 0; i < 16; i++) begin
            regs[i]  = 8'h00;
            regs2[i] = 8'h00;
        end
        bif.cmd_valid = 1'b0; bif.cmd_rd = 1'b0; bif.cmd_addr = 4'h0; bif.cmd_data = 8'h00;
        hif.cmd_valid = 1'b0; hif.cmd_rd = 1'b0; hif.cmd_addr = 4'h0; hif.cmd_data = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_high_addr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end
endmodule
